// File: rtl/blink_pkg.sv
// Shared types and defaults for the LED blink sequencer.
// Holds the FSM state encoding and default timer/repeat widths.
package blink_pkg;

    localparam int CNT_W_DEF = 3;
    localparam int REP_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        DONE
    } blink_state_t;

endpackage

// File: rtl/blink_sequencer_phase_timer.sv
// Reloadable down-timer measuring one ON or OFF phase.
// Ports: i_clk, i_rst_n, i_load/i_val (reload), o_timeout (count at 0).
module phase_timer #(
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_timeout
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (i_load) begin
            count_q <= i_val;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Expiry depends on the count alone, so the sequencer can
    // reload the next phase in the very cycle it sees expiry.
    assign o_timeout = (count_q == '0);

endmodule

// File: rtl/blink_sequencer.sv
// Blink sequencer: on start, emits N blinks of T_on+1 / T_off+1 cycles,
// then pulses o_done. Ports: i_start/i_abort, config, o_led/o_busy/o_done/o_blink_cnt.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_on_time,
    input  logic [CNT_W-1:0] i_off_time,
    input  logic [REP_W-1:0] i_repeats,
    output logic             o_led,
    output logic             o_busy,
    output logic             o_done,
    output logic [REP_W-1:0] o_blink_cnt
);

    blink_state_t     state_q;
    blink_state_t     state_d;
    logic [CNT_W-1:0] on_q;
    logic [CNT_W-1:0] off_q;
    logic [REP_W-1:0] rem_q;
    logic [REP_W-1:0] cnt_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmo;
    logic             go;
    logic             blink_end;

    // Abort dominates a simultaneous start.
    assign go = i_start & ~i_abort;
    assign blink_end = (state_q == OFF) & ~i_abort & tmo;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (tmr_load),
        .i_val     (tmr_val),
        .o_timeout (tmo)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = on_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    if (i_repeats != '0) begin
                        state_d  = ON;
                        tmr_load = 1'b1;
                        tmr_val  = i_on_time;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ON: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (tmo) begin
                    state_d  = OFF;
                    tmr_load = 1'b1;
                    tmr_val  = off_q;
                end
            end
            OFF: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (tmo) begin
                    if (rem_q == REP_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d  = ON;
                        tmr_load = 1'b1;
                        tmr_val  = on_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            o_led   <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_led   <= (state_d == ON);
            o_busy  <= (state_d == ON) | (state_d == OFF);
            o_done  <= (state_d == DONE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            on_q  <= '0;
            off_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else if ((state_q == IDLE) && go) begin
            on_q  <= i_on_time;
            off_q <= i_off_time;
            rem_q <= i_repeats;
            cnt_q <= '0;
        end else if (blink_end) begin
            rem_q <= rem_q - REP_W'(1);
            cnt_q <= cnt_q + REP_W'(1);
        end
    end

    assign o_blink_cnt = cnt_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboard bench for blink_sequencer.
// Expected per-cycle outputs are queued at start and popped each cycle.
module tb_blink_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] on_time;
    logic [2:0] off_time;
    logic [3:0] repeats;
    logic       led;
    logic       busy;
    logic       done;
    logic [3:0] blink_cnt;

    typedef struct packed {
        logic       led;
        logic       busy;
        logic       done;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   errs;
    int   checks;

    blink_sequencer #(
        .CNT_W (3),
        .REP_W (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .i_on_time   (on_time),
        .i_off_time  (off_time),
        .i_repeats   (repeats),
        .o_led       (led),
        .o_busy      (busy),
        .o_done      (done),
        .o_blink_cnt (blink_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e);
        check({tag, ".led"}, int'(led), int'(e.led));
        check({tag, ".busy"}, int'(busy), int'(e.busy));
        check({tag, ".done"}, int'(done), int'(e.done));
        check({tag, ".cnt"}, int'(blink_cnt), int'(e.cnt));
    endtask

    // Per-cycle expectation straight from the blink timing:
    // T_on+1 ON cycles, T_off+1 OFF cycles per blink, then DONE, then IDLE.
    task automatic build(input int ton, input int toff, input int n);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c <= ton; c++) begin
                e = '{led: 1'b1, busy: 1'b1, done: 1'b0, cnt: 4'(b)};
                sb.push_back(e);
            end
            for (int c = 0; c <= toff; c++) begin
                e = '{led: 1'b0, busy: 1'b1, done: 1'b0, cnt: 4'(b)};
                sb.push_back(e);
            end
        end
        e = '{led: 1'b0, busy: 1'b0, done: 1'b1, cnt: 4'(n)};
        sb.push_back(e);
        e = '{led: 1'b0, busy: 1'b0, done: 1'b0, cnt: 4'(n)};
        sb.push_back(e);
    endtask

    task automatic run(input string tag, input int ton, input int toff,
                       input int n, input int abort_at, input bit noise);
        exp_t e;
        exp_t idle;
        int   idx;
        sb.delete();
        build(ton, toff, n);
        on_time  = 3'(ton);
        off_time = 3'(toff);
        repeats  = 4'(n);
        start    = 1'b1;
        idx      = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            e = sb.pop_front();
            cmp($sformatf("%s[%0d]", tag, idx), e);
            if (noise && e.busy) begin
                start    = 1'($urandom_range(0, 1));
                on_time  = 3'($urandom_range(0, 7));
                off_time = 3'($urandom_range(0, 7));
                repeats  = 4'($urandom_range(0, 15));
            end
            if (idx == abort_at) begin
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                idle = '{led: 1'b0, busy: 1'b0, done: 1'b0, cnt: e.cnt};
                cmp({tag, ".abort"}, idle);
                @(posedge clk);
                #1;
                cmp({tag, ".abort_hold"}, idle);
                sb.delete();
            end
            idx++;
        end
    endtask

    initial begin
        errs     = 0;
        checks   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        on_time  = '0;
        off_time = '0;
        repeats  = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset", exp_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp("post_reset", exp_t'(0));

        run("t2_1_3", 2, 1, 3, -1, 1'b0);
        run("t0_0_1", 0, 0, 1, -1, 1'b0);
        run("n0", 5, 2, 0, -1, 1'b0);
        // abort during the 2nd OFF phase (index 13)
        run("abort", 3, 3, 4, 13, 1'b0);

        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        cmp("start_abort", '{led: 1'b0, busy: 1'b0, done: 1'b0, cnt: 4'd1});
        @(posedge clk);
        #1;
        cmp("start_abort2", '{led: 1'b0, busy: 1'b0, done: 1'b0, cnt: 4'd1});

        run("noise", 2, 3, 3, -1, 1'b1);
        start = 1'b0;

        on_time  = 3'd3;
        off_time = 3'd0;
        repeats  = 4'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("rst_pre.led", int'(led), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        cmp("async_rst", exp_t'(0));
        #3;
        rst_n = 1'b1;
        run("restart", 1, 2, 2, -1, 1'b0);
        run("t7_7_2", 7, 7, 2, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
